// File: rtl/cnt_seq_pkg.sv
// Shared types and default widths for the cnt_seq command sequencer.
package cnt_seq_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int LEN_W_DEF = 8;
    localparam int GAP_DEF   = 1;
    localparam int GAP_CNT_W = 4;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_ARST = 2'd1,
        OP_CLK1 = 2'd2,
        OP_CLK2 = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cnt_seq_shadow.sv
// Pair of wrapping shadow counters mirroring the counter datapath; clear wins over increment.
module cnt_seq_shadow
    import cnt_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             clr,
    input  logic             inc1,
    input  logic             inc2,
    output logic [CNT_W-1:0] exp1,
    output logic [CNT_W-1:0] exp2
);

    logic [CNT_W-1:0] exp1_q, exp1_d;
    logic [CNT_W-1:0] exp2_q, exp2_d;

    always_comb begin
        exp1_d = exp1_q;
        exp2_d = exp2_q;
        if (clr) begin
            exp1_d = '0;
            exp2_d = '0;
        end else begin
            if (inc1) exp1_d = exp1_q + 1'b1;
            if (inc2) exp2_d = exp2_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            exp1_q <= '0;
            exp2_q <= '0;
        end else begin
            exp1_q <= exp1_d;
            exp2_q <= exp2_d;
        end
    end

    assign exp1 = exp1_q;
    assign exp2 = exp2_q;

endmodule

// File: rtl/cnt_seq.sv
// Command-driven pulse sequencer with shadow counter model.
// CNT_SEQ_DOUBLE_ARST_EN: ARST command emits two rst_out pulses instead of one.
module cnt_seq
    import cnt_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             tick1,
    output logic             tick2,
    output logic             rst_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] exp1,
    output logic [CNT_W-1:0] exp2,
    output state_e           dbg_state
);

`ifdef CNT_SEQ_DOUBLE_ARST_EN
    localparam int ARST_PULSES = 2;
`else
    localparam int ARST_PULSES = 1;
`endif

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, so a held command simply waits for the next IDLE.
    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [GAP_CNT_W-1:0] gap_q, gap_d;
    logic                 tick1_q, tick1_d;
    logic                 tick2_q, tick2_d;
    logic                 rst_out_q, rst_out_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d = op_e'(cmd_op);
                    if (op_d == OP_NOP || (op_d != OP_ARST && cmd_len == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PULSE;
                        rem_d   = (op_d == OP_ARST) ? LEN_W'(ARST_PULSES) : cmd_len;
                    end
                end
            end
            S_PULSE: begin
                rem_d = rem_q - 1'b1;
                if (GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = (rem_d != '0) ? S_PULSE : S_DONE;
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = (rem_q != '0) ? S_PULSE : S_DONE;
                else             gap_d   = gap_q - 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pulses are decoded from the next state so they land in registers.
        tick1_d   = (state_d == S_PULSE) && (op_d == OP_CLK1);
        tick2_d   = (state_d == S_PULSE) && (op_d == OP_CLK2);
        rst_out_d = (state_d == S_PULSE) && (op_d == OP_ARST);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            rem_q     <= '0;
            gap_q     <= '0;
            tick1_q   <= 1'b0;
            tick2_q   <= 1'b0;
            rst_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            tick1_q   <= tick1_d;
            tick2_q   <= tick2_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
        end
    end

    cnt_seq_shadow #(.CNT_W(CNT_W)) u_shadow (
        .clk  (clk),
        .arst (arst),
        .clr  (rst_out_q),
        .inc1 (tick1_q),
        .inc2 (tick2_q),
        .exp1 (exp1),
        .exp2 (exp2)
    );

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign tick1     = tick1_q;
    assign tick2     = tick2_q;
    assign rst_out   = rst_out_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cnt_seq.sv
// Self-checking bench for cnt_seq: per-cycle output trace and shadow values from a bench-side model.
module tb_cnt_seq;
    import cnt_seq_pkg::*;

    localparam int GAP = 1;
`ifdef CNT_SEQ_DOUBLE_ARST_EN
    localparam int ARST_N = 2;
`else
    localparam int ARST_N = 1;
`endif

    logic       clk;
    logic       arst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_len;
    logic       tick1, tick2, rst_out, busy, done;
    logic [7:0] exp1, exp2;
    state_e     dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Trace vector: {tick1, tick2, rst_out, done, cmd_ready, busy}
    logic [5:0]  exp_q[$];
    logic [15:0] shd_q[$];
    logic [7:0]  m1 = 8'd0;
    logic [7:0]  m2 = 8'd0;

    cnt_seq #(.CNT_W(8), .LEN_W(8), .GAP(GAP)) dut (
        .clk       (clk),
        .arst      (arst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .tick1     (tick1),
        .tick2     (tick2),
        .rst_out   (rst_out),
        .busy      (busy),
        .done      (done),
        .exp1      (exp1),
        .exp2      (exp2),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: expected per-cycle trace after an accept, plus shadow values at done.
    task automatic push_cmd(input logic [1:0] op, input logic [7:0] len);
        int n;
        n = (op == 2'd0) ? 0 : (op == 2'd1) ? ARST_N : int'(len);
        for (int i = 0; i < n; i++) begin
            case (op)
                2'd1:    begin exp_q.push_back(6'b001001); m1 = 8'd0; m2 = 8'd0; end
                2'd2:    begin exp_q.push_back(6'b100001); m1 = m1 + 8'd1; end
                default: begin exp_q.push_back(6'b010001); m2 = m2 + 8'd1; end
            endcase
            for (int g = 0; g < GAP; g++) exp_q.push_back(6'b000001);
        end
        exp_q.push_back(6'b000101);
        shd_q.push_back({m1, m2});
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        push_cmd(op, len);
    endtask

    task automatic test_reset();
        arst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_len = 8'd0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({tick1, tick2, rst_out, done, cmd_ready, busy} !== 6'b000010) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000010",
                     {tick1, tick2, rst_out, done, cmd_ready, busy});
        end
        n_tests++;
        if ({exp1, exp2} !== 16'h0000 || dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_shadow: got exp1=%0d exp2=%0d state=%0d expected 0 0 0", exp1, exp2, dbg_state);
        end
        arst = 1'b0;
    endtask

    task automatic test_arst();
        logic [5:0] obs, exp_v;
        logic [15:0] shd;
        issue(2'd1, 8'd0);
        while (exp_q.size() != 0) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            obs = {tick1, tick2, rst_out, done, cmd_ready, busy};
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL arst_trace: got %b expected %b", obs, exp_v); end
            if (exp_v[2]) begin
                shd = shd_q.pop_front();
                n_tests++;
                if ({exp1, exp2} !== shd) begin n_fail++; $display("FAIL arst_shadow: got %h expected %h", {exp1, exp2}, shd); end
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_bursts();
        logic [5:0] obs, exp_v;
        logic [15:0] shd;
        logic [1:0] ops[3] = '{2'd2, 2'd1, 2'd3};
        for (int c = 0; c < 3; c++) begin
            issue(ops[c], 8'd5);
            while (exp_q.size() != 0) begin
                @(negedge clk);
                exp_v = exp_q.pop_front();
                obs = {tick1, tick2, rst_out, done, cmd_ready, busy};
                n_tests++;
                if (obs !== exp_v) begin n_fail++; $display("FAIL burst_trace op%0d: got %b expected %b", ops[c], obs, exp_v); end
                if (exp_v[2]) begin
                    shd = shd_q.pop_front();
                    n_tests++;
                    if ({exp1, exp2} !== shd) begin n_fail++; $display("FAIL burst_shadow op%0d: got %h expected %h", ops[c], {exp1, exp2}, shd); end
                end
            end
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_wrap();
        logic [5:0] obs, exp_v;
        logic [15:0] shd;
        for (int c = 0; c < 2; c++) begin
            issue(2'd2, 8'd255);
            while (exp_q.size() != 0) begin
                @(negedge clk);
                exp_v = exp_q.pop_front();
                obs = {tick1, tick2, rst_out, done, cmd_ready, busy};
                n_tests++;
                if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_trace: got %b expected %b", obs, exp_v); end
                if (exp_v[2]) begin
                    shd = shd_q.pop_front();
                    n_tests++;
                    if ({exp1, exp2} !== shd) begin n_fail++; $display("FAIL wrap_shadow: got %h expected %h", {exp1, exp2}, shd); end
                end
            end
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_nop_len0();
        logic [5:0] obs, exp_v;
        logic [15:0] shd;
        logic [1:0] ops[3] = '{2'd0, 2'd2, 2'd3};
        for (int c = 0; c < 3; c++) begin
            issue(ops[c], 8'd0);
            while (exp_q.size() != 0) begin
                @(negedge clk);
                exp_v = exp_q.pop_front();
                obs = {tick1, tick2, rst_out, done, cmd_ready, busy};
                n_tests++;
                if (obs !== exp_v) begin n_fail++; $display("FAIL nop_trace op%0d: got %b expected %b", ops[c], obs, exp_v); end
                if (exp_v[2]) begin
                    shd = shd_q.pop_front();
                    n_tests++;
                    if ({exp1, exp2} !== shd) begin n_fail++; $display("FAIL nop_shadow op%0d: got %h expected %h", ops[c], {exp1, exp2}, shd); end
                end
            end
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_abort();
        int ticks;
        issue(2'd2, 8'd10);
        exp_q.delete();
        shd_q.delete();
        ticks = 0;
        for (int cyc = 0; cyc < 40 && ticks < 3; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (tick1 === 1'b1) ticks++;
        end
        n_tests++;
        if (ticks != 3) begin n_fail++; $display("FAIL abort_ticks: got %0d ticks expected 3", ticks); end
        @(negedge clk);
        arst = 1'b1;
        #1;
        m1 = 8'd0;
        m2 = 8'd0;
        n_tests++;
        if ({tick1, tick2, rst_out, done, busy} !== 5'b0 || {exp1, exp2} !== {m1, m2}) begin
            n_fail++;
            $display("FAIL abort_clear: got pulses=%b busy=%b exp1=%0d exp2=%0d expected all 0",
                     {tick1, tick2, rst_out, done}, busy, exp1, exp2);
        end
        @(negedge clk);
        arst = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            n_tests++;
            if ({tick1, tick2, rst_out, done} !== 4'b0) begin
                n_fail++;
                $display("FAIL abort_quiet cyc%0d: got %b expected 0000", cyc, {tick1, tick2, rst_out, done});
            end
        end
        n_tests++;
        if (cmd_ready !== 1'b1 || exp1 !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_recover: got ready=%b exp1=%0d expected 1 0", cmd_ready, exp1);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] obs, exp_v;
        logic [15:0] shd;
        logic [7:0] len_a, len_b;
        bit first;
        len_a = 8'($urandom_range(1, 4));
        len_b = 8'($urandom_range(1, 4));
        issue(2'd3, len_a);
        exp_q.push_back(6'b000010);
        push_cmd(2'd2, len_b);
        first = 1'b1;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            if (first) begin
                cmd_op  = 2'd2;
                cmd_len = len_b;
                first   = 1'b0;
            end
            exp_v = exp_q.pop_front();
            obs = {tick1, tick2, rst_out, done, cmd_ready, busy};
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_trace: got %b expected %b", obs, exp_v); end
            if (exp_v[2]) begin
                shd = shd_q.pop_front();
                n_tests++;
                if ({exp1, exp2} !== shd) begin n_fail++; $display("FAIL b2b_shadow: got %h expected %h", {exp1, exp2}, shd); end
            end
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({tick1, tick2, rst_out, done, cmd_ready, busy} !== 6'b000010) begin
            n_fail++;
            $display("FAIL b2b_idle: got %b expected 000010", {tick1, tick2, rst_out, done, cmd_ready, busy});
        end
    endtask

    initial begin
        test_reset();
        test_arst();
        test_bursts();
        test_wrap();
        test_nop_len0();
        test_abort();
        test_back_to_back();
        test_arst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
